// File: rtl/concat2d_stream_sched.sv
// concat2d_stream_sched: serialises A elements then B elements per frame through one output register.
module concat2d_stream_sched #(
  parameter int A_CH  = 1,
  parameter int B_CH  = 1,
  parameter int IN_H  = 1,
  parameter int IN_W  = 1,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic signed [WIDTH-1:0] a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic signed [WIDTH-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    out_sel_b,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int A_BEATS = A_CH * IN_H * IN_W;
  localparam int B_BEATS = B_CH * IN_H * IN_W;
  localparam int MAX_BEATS = A_BEATS > B_BEATS ? A_BEATS : B_BEATS;
  localparam int CW = $clog2(MAX_BEATS + 1);
  typedef enum logic {S_A, S_B} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, sel_q, sel_d, fd_q, fd_d;
  logic pipe_ready, acc, wrap, end_b;
  always_comb begin
    pipe_ready = !valid_q || out_ready;
    a_ready = (st_q == S_A) && pipe_ready;
    b_ready = (st_q == S_B) && pipe_ready;
    acc = (a_valid && a_ready) || (b_valid && b_ready);
    end_b = (st_q == S_B) && (cnt_q == CW'(B_BEATS - 1));
    wrap = end_b || ((st_q == S_A) && (cnt_q == CW'(A_BEATS - 1)));
    cnt_d = acc ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    st_d = (acc && wrap) ? ((st_q == S_A) ? S_B : S_A) : st_q;
    valid_d = acc || (valid_q && !out_ready);
    data_d = acc ? ((st_q == S_B) ? b_data : a_data) : data_q;
    sel_d = acc ? (st_q == S_B) : sel_q;
    last_d = acc ? end_b : last_q;
    fd_d = valid_q && out_ready && last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_A;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      sel_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      data_q <= data_d;
      last_q <= last_d;
      sel_q <= sel_d;
      fd_q <= fd_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_last = last_q;
  assign out_sel_b = sel_q;
  assign frame_done = fd_q;
  assign busy = (st_q == S_B) || (cnt_q != '0) || (valid_q && !last_q);
endmodule

// File: tb/tb_concat2d_stream_sched.sv
// tb_concat2d_stream_sched: directed checks of the concat scheduler in a 2/1/2/2 and a 1/1/1/1 build.
module tb_concat2d_stream_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 0, a_ready, b_valid = 0, b_ready, out_valid, out_ready = 0;
  logic out_last, out_sel_b, frame_done, busy;
  logic signed [15:0] a_data = 0, b_data = 0, out_data;
  logic a_valid1 = 0, a_ready1, b_valid1 = 0, b_ready1, out_valid1, out_ready1 = 0;
  logic out_last1, out_sel_b1, frame_done1, busy1;
  logic signed [15:0] a_data1 = 0, b_data1 = 0, out_data1;
  int total = 0, bad = 0;
  int a_sent, b_sent, o_cnt, fd_cnt, a_lim, b_lim;
  int a_sent1, b_sent1, o_cnt1, fd_cnt1, a_lim1, b_lim1;
  bit hs_a, hs_b, xfer, hs_a1, hs_b1, xfer1;
  logic [15:0] exp_d;
  logic exp_sel, exp_last, fd_exp;

  always #5 clk = ~clk;

  concat2d_stream_sched #(.A_CH(2), .B_CH(1), .IN_H(2), .IN_W(2), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_sel_b(out_sel_b),
    .frame_done(frame_done), .busy(busy));

  concat2d_stream_sched #(.A_CH(1), .B_CH(1), .IN_H(1), .IN_W(1), .WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1),
    .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1), .out_sel_b(out_sel_b1),
    .frame_done(frame_done1), .busy(busy1));

  task automatic do_reset();
    a_valid = 0; b_valid = 0; a_valid1 = 0; b_valid1 = 0; out_ready = 1; out_ready1 = 1;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    a_sent = 0; b_sent = 0; o_cnt = 0; fd_cnt = 0; a_lim = 0; b_lim = 0;
    a_sent1 = 0; b_sent1 = 0; o_cnt1 = 0; fd_cnt1 = 0; a_lim1 = 0; b_lim1 = 0;
    fd_exp = 0;
  endtask

  task automatic drive(input bit ordy);
    out_ready = ordy;
    a_valid = a_sent < a_lim;
    b_valid = b_sent < b_lim;
    a_data = 16'((a_sent % 8) + 1);
    b_data = 16'(101 + (b_sent % 4));
    #1;
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    xfer = out_valid && out_ready;
    exp_d = (o_cnt % 12) < 8 ? 16'((o_cnt % 12) + 1) : 16'(93 + (o_cnt % 12));
    exp_sel = (o_cnt % 12) >= 8;
    exp_last = (o_cnt % 12) == 11;
  endtask

  task automatic tick();
    fd_exp = xfer && exp_last;
    @(posedge clk); #1;
    if (hs_a) a_sent++;
    if (hs_b) b_sent++;
    if (xfer) o_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic drive1();
    out_ready1 = 1;
    a_valid1 = a_sent1 < a_lim1;
    b_valid1 = b_sent1 < b_lim1;
    a_data1 = 16'(11 + a_sent1);
    b_data1 = 16'(201 + b_sent1);
    #1;
    hs_a1 = a_valid1 && a_ready1;
    hs_b1 = b_valid1 && b_ready1;
    xfer1 = out_valid1 && out_ready1;
  endtask

  task automatic tick1();
    @(posedge clk); #1;
    if (hs_a1) a_sent1++;
    if (hs_b1) b_sent1++;
    if (xfer1) o_cnt1++;
    if (frame_done1) fd_cnt1++;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 0;
    #1;
    total++;
    if (out_valid !== 0 || out_data !== 0 || out_last !== 0 || out_sel_b !== 0 ||
        frame_done !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%0d l=%b s=%b fd=%b busy=%b, want all 0",
               out_valid, out_data, out_last, out_sel_b, frame_done, busy);
    end
    total++;
    if (a_ready !== 1 || b_ready !== 0) begin
      bad++;
      $display("FAIL reset_ready: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
  endtask

  task automatic test_stream();
    do_reset();
    a_lim = 8; b_lim = 4;
    for (int c = 0; c < 16; c++) begin
      drive(1);
      total++;
      if (out_valid !== (c >= 1 && c <= 12) || busy !== (c >= 1 && c <= 11)) begin
        bad++;
        $display("FAIL stream_valid_busy c=%0d: got v=%b busy=%b, want v=%b busy=%b", c,
                 out_valid, busy, c >= 1 && c <= 12, c >= 1 && c <= 11);
      end
      total++;
      if (a_ready !== (a_sent < 8 || b_sent == 4) || b_ready !== (a_sent == 8 && b_sent < 4)) begin
        bad++;
        $display("FAIL stream_ready c=%0d: got a=%b b=%b, want a=%b b=%b", c, a_ready, b_ready,
                 a_sent < 8 || b_sent == 4, a_sent == 8 && b_sent < 4);
      end
      total++;
      if (frame_done !== fd_exp) begin
        bad++;
        $display("FAIL stream_frame_done c=%0d: got %b want %b", c, frame_done, fd_exp);
      end
      if (xfer) begin
        total++;
        if (out_data !== exp_d || out_sel_b !== exp_sel || out_last !== exp_last) begin
          bad++;
          $display("FAIL stream_beat %0d: got d=%0d s=%b l=%b, want d=%0d s=%b l=%b", o_cnt,
                   out_data, out_sel_b, out_last, exp_d, exp_sel, exp_last);
        end
      end
      tick();
    end
    total++;
    if (o_cnt !== 12 || fd_cnt !== 1) begin
      bad++;
      $display("FAIL stream_count: got beats=%0d done=%0d, want 12 1", o_cnt, fd_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    a_lim = 8; b_lim = 4;
    for (int c = 0; c < 40 && o_cnt < 12; c++) begin
      drive(c % 2 == 0);
      if (out_valid && !out_ready) begin
        total++;
        if (a_ready !== 0 || b_ready !== 0) begin
          bad++;
          $display("FAIL stall_ready c=%0d: got a=%b b=%b, want 0 0", c, a_ready, b_ready);
        end
      end
      if (out_valid) begin
        total++;
        if (out_data !== exp_d || out_sel_b !== exp_sel || out_last !== exp_last) begin
          bad++;
          $display("FAIL stall_beat %0d: got d=%0d s=%b l=%b, want d=%0d s=%b l=%b", o_cnt,
                   out_data, out_sel_b, out_last, exp_d, exp_sel, exp_last);
        end
      end
      tick();
    end
    drive(1);
    tick();
    total++;
    if (o_cnt !== 12 || fd_cnt !== 1 || busy !== 0) begin
      bad++;
      $display("FAIL stall_count: got beats=%0d done=%0d busy=%b, want 12 1 0", o_cnt, fd_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_lim = 24; b_lim = 12;
    for (int c = 0; c < 40; c++) begin
      drive(1);
      total++;
      if (out_valid !== (c >= 1 && c <= 36) || frame_done !== fd_exp) begin
        bad++;
        $display("FAIL b2b_valid c=%0d: got v=%b fd=%b, want v=%b fd=%b", c, out_valid,
                 frame_done, c >= 1 && c <= 36, fd_exp);
      end
      if (xfer) begin
        total++;
        if (out_data !== exp_d || out_sel_b !== exp_sel || out_last !== exp_last) begin
          bad++;
          $display("FAIL b2b_beat %0d: got d=%0d s=%b l=%b, want d=%0d s=%b l=%b", o_cnt,
                   out_data, out_sel_b, out_last, exp_d, exp_sel, exp_last);
        end
      end
      tick();
    end
    total++;
    if (o_cnt !== 36 || fd_cnt !== 3) begin
      bad++;
      $display("FAIL b2b_count: got beats=%0d done=%0d, want 36 3", o_cnt, fd_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    a_lim = 8; b_lim = 4;
    for (int c = 0; c < 5; c++) begin
      drive(1);
      tick();
    end
    do_reset();
    #1;
    total++;
    if (out_valid !== 0 || out_data !== 0 || out_last !== 0 || out_sel_b !== 0 ||
        frame_done !== 0 || busy !== 0 || a_ready !== 1 || b_ready !== 0) begin
      bad++;
      $display("FAIL midrst_outputs: got v=%b d=%0d l=%b s=%b fd=%b busy=%b ar=%b br=%b, want 0s ar=1",
               out_valid, out_data, out_last, out_sel_b, frame_done, busy, a_ready, b_ready);
    end
    a_lim = 8; b_lim = 4;
    for (int c = 0; c < 20; c++) begin
      drive(1);
      if (xfer) begin
        total++;
        if (out_data !== exp_d || out_sel_b !== exp_sel || out_last !== exp_last) begin
          bad++;
          $display("FAIL midrst_beat %0d: got d=%0d s=%b l=%b, want d=%0d s=%b l=%b", o_cnt,
                   out_data, out_sel_b, out_last, exp_d, exp_sel, exp_last);
        end
      end
      tick();
    end
    total++;
    if (o_cnt !== 12 || fd_cnt !== 1) begin
      bad++;
      $display("FAIL midrst_count: got beats=%0d done=%0d, want 12 1", o_cnt, fd_cnt);
    end
  endtask

  task automatic test_unit_frames();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      a_lim1 = f + 1; b_lim1 = f + 1;
      for (int c = 0; c < 5; c++) begin
        drive1();
        if (xfer1) begin
          total++;
          if (out_data1 !== ((o_cnt1 % 2 == 0) ? 16'(11 + o_cnt1 / 2) : 16'(201 + o_cnt1 / 2)) ||
              out_sel_b1 !== (o_cnt1 % 2 == 1) || out_last1 !== (o_cnt1 % 2 == 1)) begin
            bad++;
            $display("FAIL unit_beat %0d: got d=%0d s=%b l=%b, want d=%0d s=%b l=%b", o_cnt1,
                     out_data1, out_sel_b1, out_last1,
                     (o_cnt1 % 2 == 0) ? 11 + o_cnt1 / 2 : 201 + o_cnt1 / 2,
                     o_cnt1 % 2 == 1, o_cnt1 % 2 == 1);
          end
        end
        tick1();
      end
      total++;
      if (busy1 !== 0 || fd_cnt1 !== f + 1 || o_cnt1 !== 2 * (f + 1)) begin
        bad++;
        $display("FAIL unit_frame %0d: got busy=%b done=%0d beats=%0d, want 0 %0d %0d", f,
                 busy1, fd_cnt1, o_cnt1, f + 1, 2 * (f + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_unit_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
